bram_tdp_be: RTL and testbench

//  Single-clock true dual-port block RAM with per-byte write enables, selectable read latency,
//  per-port read-during-write mode, hardware memory clear (on reset and on demand), read-valid

---
 rtl/bram_tdp_be_if.sv | 18 +
 rtl/bram_tdp_be.sv | 139 +++++++++++++
 tb/tb_bram_tdp_be.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_tdp_be_if.sv
// One RAM access port: request (en/we/addr/din) and registered result (dout/valid).
interface bram_tdp_be_if #(
  parameter int DATA = 32,
  parameter int ADDR = 6,
  parameter int BYTE = 8
);
  localparam int NB = DATA / BYTE;

  logic            en;
  logic [NB-1:0]   we;
  logic [ADDR-1:0] addr;
  logic [DATA-1:0] din;
  logic [DATA-1:0] dout;
  logic            valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/bram_tdp_be.sv
// Single-clock true dual-port RAM with byte enables, 1/2-cycle read latency,
// per-port read-during-write mode, zero sweep on reset/clr and collision flag.
//
//  state   | meaning
//  --------+----------------------------------------------------
//  S_IDLE  | normal operation, both ports serviced
//  S_CLEAR | writing 0 to mem[ptr], ptr = 0..DEPTH-1; ports dropped
module bram_tdp_be #(
  parameter int DATA       = 32,
  parameter int ADDR       = 6,
  parameter int BYTE       = 8,
  parameter int RD_LAT     = 1,
  parameter int A_MODE     = 0,
  parameter int B_MODE     = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          collision,
  bram_tdp_be_if.slave  a,
  bram_tdp_be_if.slave  b
);
  localparam int NB    = DATA / BYTE;
  localparam int DEPTH = 1 << ADDR;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ADDR-1:0] ptr_q, ptr_d;
  logic [DATA-1:0] mem_q [DEPTH];

  logic            a_act, b_act, a_wr, b_wr;
  logic [DATA-1:0] a_old, b_old, a_merge, b_merge;
  logic [DATA-1:0] a_s1_dout_q, a_s1_dout_d, b_s1_dout_q, b_s1_dout_d;
  logic            a_s1_vld_q, a_s1_vld_d, b_s1_vld_q, b_s1_vld_d;
  logic [DATA-1:0] a_s2_dout_q, a_s2_dout_d, b_s2_dout_q, b_s2_dout_d;
  logic            a_s2_vld_q, a_s2_vld_d, b_s2_vld_q, b_s2_vld_d;
  logic            collision_q, collision_d;

  assign busy = (state_q == S_CLEAR);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Both ports read the pre-edge word, so a cross-port read never sees the other port's write.
  always_comb begin
    a_act   = a.en && !busy;
    b_act   = b.en && !busy;
    a_wr    = a_act && (|a.we);
    b_wr    = b_act && (|b.we);
    a_old   = mem_q[a.addr];
    b_old   = mem_q[b.addr];
    a_merge = a_old;
    b_merge = b_old;
    for (int i = 0; i < NB; i++) begin
      if (a.we[i]) a_merge[i*BYTE +: BYTE] = a.din[i*BYTE +: BYTE];
      if (b.we[i]) b_merge[i*BYTE +: BYTE] = b.din[i*BYTE +: BYTE];
    end

    a_s1_vld_d  = a_act && !(a_wr && (A_MODE == 2));
    b_s1_vld_d  = b_act && !(b_wr && (B_MODE == 2));
    a_s1_dout_d = a_s1_dout_q;
    b_s1_dout_d = b_s1_dout_q;
    if (a_s1_vld_d) a_s1_dout_d = (A_MODE == 0) ? a_merge : a_old;
    if (b_s1_vld_d) b_s1_dout_d = (B_MODE == 0) ? b_merge : b_old;

    a_s2_dout_d = a_s1_dout_q;
    a_s2_vld_d  = a_s1_vld_q;
    b_s2_dout_d = b_s1_dout_q;
    b_s2_vld_d  = b_s1_vld_q;

    collision_d = a_act && b_act && (a.addr == b.addr) && (a_wr || b_wr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      ptr_q       <= '0;
      a_s1_dout_q <= '0;
      a_s1_vld_q  <= 1'b0;
      b_s1_dout_q <= '0;
      b_s1_vld_q  <= 1'b0;
      a_s2_dout_q <= '0;
      a_s2_vld_q  <= 1'b0;
      b_s2_dout_q <= '0;
      b_s2_vld_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_s1_dout_q <= a_s1_dout_d;
      a_s1_vld_q  <= a_s1_vld_d;
      b_s1_dout_q <= b_s1_dout_d;
      b_s1_vld_q  <= b_s1_vld_d;
      a_s2_dout_q <= a_s2_dout_d;
      a_s2_vld_q  <= a_s2_vld_d;
      b_s2_dout_q <= b_s2_dout_d;
      b_s2_vld_q  <= b_s2_vld_d;
      collision_q <= collision_d;
    end
  end

  // Port A lanes are written after port B so A wins on lanes both ports write.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_act && b.we[i]) mem_q[b.addr][i*BYTE +: BYTE] <= b.din[i*BYTE +: BYTE];
        if (a_act && a.we[i]) mem_q[a.addr][i*BYTE +: BYTE] <= a.din[i*BYTE +: BYTE];
      end
    end
  end

  assign a.dout    = (RD_LAT == 2) ? a_s2_dout_q : a_s1_dout_q;
  assign a.valid   = (RD_LAT == 2) ? a_s2_vld_q  : a_s1_vld_q;
  assign b.dout    = (RD_LAT == 2) ? b_s2_dout_q : b_s1_dout_q;
  assign b.valid   = (RD_LAT == 2) ? b_s2_vld_q  : b_s1_vld_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_bram_tdp_be.sv
// Randomized bench for bram_tdp_be: three instances with different latency/mode
// settings share one stimulus stream and are compared against a behavioural model.
module tb_bram_tdp_be;
  localparam int DATA  = 32;
  localparam int ADDR  = 6;
  localparam int BYTE  = 8;
  localparam int NB    = 4;
  localparam int DEPTH = 64;
  localparam int NI    = 3;

  logic clk = 1'b0;
  logic rst, clr;
  logic a_en, b_en;
  logic [NB-1:0]   a_we, b_we;
  logic [ADDR-1:0] a_addr, b_addr;
  logic [DATA-1:0] a_din, b_din;

  logic [DATA-1:0] a_dout_w [NI];
  logic [DATA-1:0] b_dout_w [NI];
  logic            a_vld_w [NI];
  logic            b_vld_w [NI];
  logic            busy_w [NI];
  logic            coll_w [NI];

  always #5 clk = ~clk;

  // instance 0: lat1 A write-first B read-first; 1: lat2 A no-change B write-first; 2: lat1 A read-first B no-change
  for (genvar g = 0; g < NI; g++) begin : g_dut
    bram_tdp_be_if #(.DATA(DATA), .ADDR(ADDR), .BYTE(BYTE)) ia ();
    bram_tdp_be_if #(.DATA(DATA), .ADDR(ADDR), .BYTE(BYTE)) ib ();
    assign ia.en = a_en;  assign ia.we = a_we;  assign ia.addr = a_addr;  assign ia.din = a_din;
    assign ib.en = b_en;  assign ib.we = b_we;  assign ib.addr = b_addr;  assign ib.din = b_din;
    bram_tdp_be #(
      .DATA(DATA), .ADDR(ADDR), .BYTE(BYTE),
      .RD_LAT(g == 1 ? 2 : 1),
      .A_MODE(g == 0 ? 0 : (g == 1 ? 2 : 1)),
      .B_MODE(g == 0 ? 1 : (g == 1 ? 0 : 2)),
      .CLR_ON_RST(1)
    ) u_dut (
      .clk(clk), .rst(rst), .clr(clr),
      .busy(busy_w[g]), .collision(coll_w[g]),
      .a(ia.slave), .b(ib.slave)
    );
    assign a_dout_w[g] = ia.dout;
    assign a_vld_w[g]  = ia.valid;
    assign b_dout_w[g] = ib.dout;
    assign b_vld_w[g]  = ib.valid;
  end

  int errors = 0;
  int checks = 0;

  logic [DATA-1:0] mm [DEPTH];
  int              ptr_m;
  bit              busy_m;
  bit              coll_m;
  logic [DATA-1:0] hist_d [NI][2][2];   // [inst][port][age]: age 0 = newest result
  bit              hist_v [NI][2][2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mode_of(int i, int p);
    if (p == 0) return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  function automatic int lat_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  task automatic model_reset();
    ptr_m  = 0;
    busy_m = 1'b1;
    coll_m = 1'b0;
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < 2; k++) begin
          hist_d[i][p][k] = '0;
          hist_v[i][p][k] = 1'b0;
        end
  endtask

  task automatic model_step();
    bit              en [2];
    logic [NB-1:0]   we [2];
    int              ad [2];
    logic [DATA-1:0] dn [2];
    logic [DATA-1:0] old [2];
    logic [DATA-1:0] own [2];
    logic [DATA-1:0] nd;
    bit              nv;
    if (rst) return;
    en[0] = a_en; we[0] = a_we; ad[0] = int'(a_addr); dn[0] = a_din;
    en[1] = b_en; we[1] = b_we; ad[1] = int'(b_addr); dn[1] = b_din;
    for (int p = 0; p < 2; p++) begin
      old[p] = mm[ad[p]];
      own[p] = old[p];
      for (int k = 0; k < NB; k++)
        if (we[p][k]) own[p][k*BYTE +: BYTE] = dn[p][k*BYTE +: BYTE];
    end
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++) begin
        nd = hist_d[i][p][0];
        nv = 1'b0;
        if (!busy_m && en[p]) begin
          if (we[p] == 0)                  begin nd = old[p]; nv = 1'b1; end
          else if (mode_of(i, p) == 0)     begin nd = own[p]; nv = 1'b1; end
          else if (mode_of(i, p) == 1)     begin nd = old[p]; nv = 1'b1; end
        end
        hist_d[i][p][1] = hist_d[i][p][0];
        hist_v[i][p][1] = hist_v[i][p][0];
        hist_d[i][p][0] = nd;
        hist_v[i][p][0] = nv;
      end
    if (busy_m) begin
      coll_m = 1'b0;
      mm[ptr_m] = '0;
      ptr_m++;
      if (ptr_m == DEPTH) begin
        busy_m = 1'b0;
        ptr_m  = 0;
      end
    end else begin
      coll_m = en[0] && en[1] && (ad[0] == ad[1]) && (we[0] != 0 || we[1] != 0);
      // B's lanes first, then A's, so lanes written by both end up with A's data
      for (int p = 1; p >= 0; p--)
        if (en[p])
          for (int k = 0; k < NB; k++)
            if (we[p][k]) mm[ad[p]][k*BYTE +: BYTE] = dn[p][k*BYTE +: BYTE];
      if (clr) begin
        busy_m = 1'b1;
        ptr_m  = 0;
      end
    end
  endtask

  task automatic check_all();
    int age;
    for (int i = 0; i < NI; i++) begin
      age = lat_of(i) - 1;
      chk($sformatf("d%0d busy", i), busy_w[i], busy_m);
      chk($sformatf("d%0d collision", i), coll_w[i], coll_m);
      chk($sformatf("d%0d a_valid", i), a_vld_w[i], hist_v[i][0][age]);
      chk($sformatf("d%0d a_dout", i), a_dout_w[i], hist_d[i][0][age]);
      chk($sformatf("d%0d b_valid", i), b_vld_w[i], hist_v[i][1][age]);
      chk($sformatf("d%0d b_dout", i), b_dout_w[i], hist_d[i][1][age]);
    end
  endtask

  // Call at a negedge with inputs set; the posedge in between applies them.
  task automatic cyc();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_a(input bit en, input logic [NB-1:0] we, input int ad, input logic [DATA-1:0] dn);
    a_en = en; a_we = we; a_addr = ADDR'(ad); a_din = dn;
  endtask

  task automatic set_b(input bit en, input logic [NB-1:0] we, input int ad, input logic [DATA-1:0] dn);
    b_en = en; b_we = we; b_addr = ADDR'(ad); b_din = dn;
  endtask

  task automatic idle_in();
    set_a(1'b0, '0, 0, '0);
    set_b(1'b0, '0, 0, '0);
    clr = 1'b0;
  endtask

  task automatic rand_in(input int amax);
    set_a($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0,
          $urandom_range(0, amax), $urandom);
    set_b($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0,
          $urandom_range(0, amax), $urandom);
  endtask

  task automatic run_sweep(input bit with_writes);
    int n = 0;
    while (busy_w[0] && n < 200) begin
      if (with_writes) set_a(1'b1, '1, $urandom_range(0, DEPTH - 1), 32'hFFFF_FFFF);
      else             rand_in(DEPTH - 1);
      cyc();
      n++;
    end
    idle_in();
    chk("sweep_len", n, 64);
  endtask

  task automatic read_all_zero();
    for (int k = 0; k < DEPTH; k++) begin
      set_a(1'b1, '0, k, $urandom);
      set_b(1'b1, '0, DEPTH - 1 - k, $urandom);
      cyc();
      chk("sweep_zero_a", a_dout_w[0], 32'h0);
      chk("sweep_zero_b", b_dout_w[2], 32'h0);
    end
    idle_in();
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mm[k] = '0;
    rst = 1'b1;
    idle_in();
    model_reset();
    #1 check_all();
    @(negedge clk);
    cyc();
    rst = 1'b0;
    run_sweep(1'b0);
    read_all_zero();

    // byte-lane write and the three read-during-write modes
    set_a(1'b1, 4'hF, 5, 32'h1122_3344); cyc();
    set_a(1'b1, 4'b0101, 5, 32'hAABB_CCDD); cyc();
    chk("wf_a_dout", a_dout_w[0], 32'h11BB_33DD);
    chk("wf_a_valid", a_vld_w[0], 1'b1);
    chk("rf_a_dout", a_dout_w[2], 32'h1122_3344);
    idle_in(); cyc();
    chk("nc_a_valid", a_vld_w[1], 1'b0);
    set_a(1'b1, '0, 5, '0); cyc();
    chk("lane_merge", a_dout_w[0], 32'h11BB_33DD);

    // both ports writing the same word
    set_a(1'b1, 4'b0011, 9, 32'h0000_00AA);
    set_b(1'b1, 4'b1111, 9, 32'hFFFF_FFFF); cyc();
    chk("coll_ww", coll_w[0], 1'b1);
    chk("coll_ww_lat2", coll_w[1], 1'b1);
    set_a(1'b1, '0, 9, '0); idle_in(); set_a(1'b1, '0, 9, '0); cyc();
    chk("coll_pulse", coll_w[0], 1'b0);
    chk("ww_merge", a_dout_w[0], 32'hFFFF_00AA);

    // two-cycle latency on port B
    set_a(1'b1, 4'hF, 3, 32'h1234_5678);
    set_b(1'b1, 4'hF, 4, 32'hCAFE_F00D); cyc();
    idle_in(); cyc();
    set_b(1'b1, '0, 3, '0); cyc();
    chk("lat2_t1_valid", b_vld_w[1], 1'b0);
    set_b(1'b1, '0, 4, '0); cyc();
    chk("lat2_t2_valid", b_vld_w[1], 1'b1);
    chk("lat2_t2_dout", b_dout_w[1], 32'h1234_5678);
    idle_in(); cyc();
    chk("lat2_b2b_valid", b_vld_w[1], 1'b1);
    chk("lat2_b2b_dout", b_dout_w[1], 32'hCAFE_F00D);
    cyc();
    chk("lat2_end_valid", b_vld_w[1], 1'b0);

    // cross-port read sees the pre-cycle word
    set_a(1'b1, '0, 7, '0);
    set_b(1'b1, 4'hF, 7, 32'h5A5A_5A5A); cyc();
    chk("rw_old", a_dout_w[0], 32'h0);
    chk("coll_rw", coll_w[0], 1'b1);
    set_b(1'b0, '0, 0, '0); cyc();
    chk("rw_new", a_dout_w[0], 32'h5A5A_5A5A);

    for (int n = 0; n < 400; n++) begin
      rand_in(($urandom_range(0, 1) == 1) ? 7 : DEPTH - 1);
      clr = ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle_in();
    for (int n = 0; n < 80 && busy_m; n++) cyc();

    // reset in the middle of a clr-started sweep restarts it from address 0
    clr = 1'b1; cyc();
    clr = 1'b0;
    chk("clr_busy", busy_w[0], 1'b1);
    for (int n = 0; n < 20; n++) begin
      set_a(1'b1, '1, $urandom_range(0, DEPTH - 1), 32'hFFFF_FFFF);
      cyc();
    end
    rst = 1'b1;
    model_reset();
    #1 check_all();
    cyc();
    rst = 1'b0;
    chk("rst_busy", busy_w[0], 1'b1);
    run_sweep(1'b1);
    read_all_zero();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
